// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types for the branch path.
//   br_cond_t : 2-bit branch condition code (JMP, JGT, JLT, JEQ)
//   flags_t   : architectural flag vector {N,Z,V,C}
//   F_N/F_Z/F_V/F_C : bit positions inside flags_t
package cpu_pkg;

  typedef enum logic [1:0] {
    BR_JMP = 2'b00,
    BR_JGT = 2'b01,
    BR_JLT = 2'b10,
    BR_JEQ = 2'b11
  } br_cond_t;

  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_V = 1;
  localparam int F_C = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/branch_ctrl_cond_eval.sv
// cond_eval: purely combinational branch condition resolver.
// Ports:
//   cond  in  branch condition code
//   flags in  {N,Z,V,C} used for the decision
//   taken out 1 when the branch is taken
module cond_eval
  import cpu_pkg::*;
(
  input  br_cond_t cond,
  input  flags_t   flags,
  output logic     taken
);

  // JGT/JLT are signed comparisons: "less than" means the sign of the
  // subtraction result disagrees with the overflow flag.
  always_comb begin
    taken = 1'b0;
    unique case (cond)
      BR_JMP: taken = 1'b1;
      BR_JGT: taken = !flags[F_Z] && (flags[F_N] == flags[F_V]);
      BR_JLT: taken = (flags[F_N] != flags[F_V]);
      BR_JEQ: taken = flags[F_Z];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: branch sequencer between decode and the PC register.
// Holds the architectural NZVC flags, accepts one branch at a time, waits
// for in-flight flag producers, resolves the condition and, when taken,
// redirects the PC and flushes fetch/decode.
// Ports:
//   clk, rst     clock / synchronous active-high reset
//   br_valid     decode presents a branch (accepted when br_ready is high)
//   br_cond      00 JMP, 01 JGT, 10 JLT, 11 JEQ
//   br_target    branch destination
//   flag_we      ALU writes flags this cycle
//   alu_flags    {N,Z,V,C} from the ALU
//   flag_pend    a flag-setting instruction is still in EX/MEM
//   br_ready     sequencer can accept a branch
//   stall        hold fetch/decode
//   pc_load      one-cycle PC redirect strobe
//   pc_target    registered redirect address
//   flush        squash fetch/decode contents
//   flags_q      architectural {N,Z,V,C}
//   timeout_err  one-cycle pulse when waiting for flags gives up
module branch_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int FLUSH_CYC = 2,
  parameter int WAIT_MAX  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid,
  input  logic [1:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  input  logic            flag_we,
  input  logic [3:0]      alu_flags,
  input  logic            flag_pend,
  output logic            br_ready,
  output logic            stall,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_target,
  output logic            flush,
  output logic [3:0]      flags_q,
  output logic            timeout_err
);

  localparam int WCW = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);
  localparam logic [3:0]     FL_INIT   = 4'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_FLAGS,
    S_REDIRECT,
    S_FLUSH
  } state_t;

  state_t          state, state_nxt;
  logic [WCW-1:0]  wait_cnt, wait_cnt_nxt;
  logic [3:0]      fl_cnt, fl_cnt_nxt;
  br_cond_t        cond_q;
  logic [PC_W-1:0] tgt_q;
  logic            latch_br;
  flags_t          feff;
  br_cond_t        eval_cond;
  logic            taken;

  // A flag write in the same cycle overrides the stored flags, so a branch
  // behind the producing instruction sees the fresh result without waiting.
  assign feff      = flag_we ? alu_flags : flags_q;
  assign eval_cond = (state == S_IDLE) ? br_cond_t'(br_cond) : cond_q;
  assign pc_target = tgt_q;

  cond_eval u_cond_eval (
    .cond  (eval_cond),
    .flags (feff),
    .taken (taken)
  );

  // Next-state and output decode.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    fl_cnt_nxt   = fl_cnt;
    latch_br     = 1'b0;
    br_ready     = 1'b0;
    stall        = 1'b0;
    pc_load      = 1'b0;
    flush        = 1'b0;
    timeout_err  = 1'b0;
    unique case (state)
      S_IDLE: begin
        br_ready = 1'b1;
        if (br_valid) begin
          latch_br = 1'b1;
          if (br_cond_t'(br_cond) == BR_JMP) begin
            state_nxt = S_REDIRECT;
          end else if (flag_pend && !flag_we) begin
            stall        = 1'b1;
            state_nxt    = S_WAIT_FLAGS;
            wait_cnt_nxt = '0;
          end else if (taken) begin
            state_nxt = S_REDIRECT;
          end
        end
      end
      S_WAIT_FLAGS: begin
        stall = 1'b1;
        if (flag_we) begin
          state_nxt = taken ? S_REDIRECT : S_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_err = 1'b1;
          state_nxt   = taken ? S_REDIRECT : S_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      S_REDIRECT: begin
        pc_load = 1'b1;
        flush   = 1'b1;
        if (FLUSH_CYC == 1) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt  = S_FLUSH;
          fl_cnt_nxt = FL_INIT;
        end
      end
      S_FLUSH: begin
        // The REDIRECT cycle already counted as the first flush cycle, so
        // this state lasts FLUSH_CYC-1 cycles and leaves as fl_cnt reaches 0.
        flush      = 1'b1;
        fl_cnt_nxt = fl_cnt - 4'd1;
        if (fl_cnt == 4'd1) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters, latched branch and the architectural flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fl_cnt   <= '0;
      cond_q   <= BR_JMP;
      tgt_q    <= '0;
      flags_q  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      fl_cnt   <= fl_cnt_nxt;
      if (latch_br) begin
        cond_q <= br_cond_t'(br_cond);
        tgt_q  <= br_target;
      end
      if (flag_we) begin
        flags_q <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: self-checking bench for branch_ctrl.
// Branches are driven one at a time; a transaction-level model predicts,
// from the condition rules and the flag timing, when pc_load, flush,
// timeout_err and br_ready must appear.
module tb_branch_ctrl;

  localparam int PC_W      = 32;
  localparam int FLUSH_CYC = 2;
  localparam int WAIT_MAX  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            br_valid;
  logic [1:0]      br_cond;
  logic [PC_W-1:0] br_target;
  logic            flag_we;
  logic [3:0]      alu_flags;
  logic            flag_pend;
  logic            br_ready;
  logic            stall;
  logic            pc_load;
  logic [PC_W-1:0] pc_target;
  logic            flush;
  logic [3:0]      flags_q;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;
  logic [3:0] model_flags = 4'b0000;

  typedef struct {
    int st0; int st; int ld; int ldn; int fl; int rdy; int to; int ton;
    logic [31:0] ld_tgt; logic [31:0] end_tgt;
  } obs_t;

  typedef struct {
    int st; int ld; int fl; int rdy; int to; logic [3:0] flags_after;
  } exp_t;

  branch_ctrl #(.PC_W(PC_W), .FLUSH_CYC(FLUSH_CYC), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_cond(br_cond),
    .br_target(br_target), .flag_we(flag_we), .alu_flags(alu_flags),
    .flag_pend(flag_pend), .br_ready(br_ready), .stall(stall),
    .pc_load(pc_load), .pc_target(pc_target), .flush(flush),
    .flags_q(flags_q), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit model_taken(input logic [1:0] c, input logic [3:0] f);
    bit n, z, v;
    n = f[3]; z = f[2]; v = f[1];
    case (c)
      2'd0:    return 1'b1;
      2'd1:    return (z == 1'b0) && (n == v);
      2'd2:    return n ^ v;
      default: return z;
    endcase
  endfunction

  // mode 0: no pending producer; 1: producer writes in the branch cycle;
  // 2: producer pending, writes w cycles later (w==0: never writes).
  function automatic exp_t model_branch(input logic [1:0] c, input int mode,
                                        input int w, input logic [3:0] nf,
                                        input logic [3:0] old);
    exp_t e;
    int r;
    bit tmo;
    logic [3:0] use_f;
    tmo = 1'b0;
    e.flags_after = (mode == 1) ? nf : old;
    if (c == 2'd0 || mode != 2) begin
      r = 0; use_f = e.flags_after;
    end else if (w >= 1 && w <= WAIT_MAX) begin
      r = w; use_f = nf; e.flags_after = nf;
    end else begin
      r = WAIT_MAX; tmo = 1'b1; use_f = old;
    end
    e.st  = (r > 0) ? r + 1 : 0;
    e.to  = tmo ? r : -1;
    if (model_taken(c, use_f)) begin
      e.ld = r + 1; e.fl = FLUSH_CYC; e.rdy = r + 1 + FLUSH_CYC;
    end else begin
      e.ld = -1; e.fl = 0; e.rdy = r + 1;
    end
    return e;
  endfunction

  task automatic set_flags(input logic [3:0] f);
    @(posedge clk); #1;
    flag_we = 1'b1; alu_flags = f;
    @(posedge clk); #1;
    flag_we = 1'b0;
    model_flags = f;
  endtask

  // Presents one branch in cycle 0 and watches until br_ready returns.
  // With hold set, br_valid stays high with garbage cond/target while busy.
  task automatic drive_branch(input logic [1:0] c, input logic [31:0] tgt,
                              input int mode, input int w, input logic [3:0] nf,
                              input bit hold, output obs_t o);
    o = '{st0: 0, st: 0, ld: -1, ldn: 0, fl: 0, rdy: -1, to: -1, ton: 0,
          ld_tgt: 32'h0, end_tgt: 32'h0};
    @(posedge clk); #1;
    br_valid = 1'b1; br_cond = c; br_target = tgt;
    flag_pend = (mode != 0);
    flag_we = (mode == 1);
    alu_flags = (mode == 1) ? nf : 4'($urandom);
    @(negedge clk);
    o.st0 = int'(stall);
    if (stall) o.st++;
    if (pc_load) o.ldn++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      flag_we = 1'b0; alu_flags = 4'($urandom);
      if (hold) begin
        br_cond = 2'($urandom); br_target = $urandom;
      end else begin
        br_valid = 1'b0;
      end
      if (mode == 1) flag_pend = 1'b0;
      if (mode == 2 && w == k) begin
        flag_we = 1'b1; alu_flags = nf; flag_pend = 1'b0;
      end
      @(negedge clk);
      if (pc_load) begin
        o.ldn++;
        if (o.ld < 0) begin o.ld = k; o.ld_tgt = pc_target; end
      end
      if (flush) o.fl++;
      if (timeout_err) begin
        o.ton++;
        if (o.to < 0) o.to = k;
      end
      if (br_ready) begin
        o.rdy = k; o.end_tgt = pc_target;
        break;
      end
      if (stall) o.st++;
    end
    br_valid = 1'b0; flag_pend = 1'b0; flag_we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({br_ready, stall, pc_load, flush, timeout_err} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b exp 10000", {br_ready, stall, pc_load, flush, timeout_err});
    end
    checks++;
    if (flags_q !== 4'b0000 || pc_target !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_regs got flags %b target %h exp 0000 0", flags_q, pc_target);
    end
    // Reset while flushing a taken JMP that also wrote flags.
    @(posedge clk); #1;
    br_valid = 1'b1; br_cond = 2'd0; br_target = 32'h55;
    flag_we = 1'b1; alu_flags = 4'b1111;
    @(posedge clk); #1;
    br_valid = 1'b0; flag_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || flags_q !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL reset_preflush got flush %b flags %b exp 1 1111", flush, flags_q);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({br_ready, pc_load, flush, stall} !== 4'b1000 || flags_q !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_midflush got rdy/ld/fl/st %b flags %b exp 1000 0000",
               {br_ready, pc_load, flush, stall}, flags_q);
    end
    // Reset while waiting on flags discards the branch.
    @(posedge clk); #1;
    br_valid = 1'b1; br_cond = 2'd3; br_target = 32'h77; flag_pend = 1'b1;
    @(posedge clk); #1;
    br_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flag_pend = 1'b0;
    @(negedge clk);
    checks++;
    if ({br_ready, stall, pc_load, flush} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset_midwait got rdy/st/ld/fl %b exp 1000", {br_ready, stall, pc_load, flush});
    end
    model_flags = 4'b0000;
  endtask

  task automatic test_jmp();
    obs_t o;
    drive_branch(2'd0, 32'h100, 0, 0, 4'b0, 1'b0, o);
    checks++;
    if (o.ld !== 1 || o.ld_tgt !== 32'h100) begin
      errors++;
      $display("[TB] FAIL jmp_load got cyc %0d tgt %h exp 1 100", o.ld, o.ld_tgt);
    end
    checks++;
    if (o.fl !== 2 || o.rdy !== 3 || o.st !== 0) begin
      errors++;
      $display("[TB] FAIL jmp_timing got fl %0d rdy %0d st %0d exp 2 3 0", o.fl, o.rdy, o.st);
    end
  endtask

  task automatic test_jgt();
    obs_t o;
    set_flags(4'b0000);
    drive_branch(2'd1, 32'h200, 0, 0, 4'b0, 1'b0, o);
    checks++;
    if (o.ld !== 1 || o.ld_tgt !== 32'h200) begin
      errors++;
      $display("[TB] FAIL jgt_taken got cyc %0d tgt %h exp 1 200", o.ld, o.ld_tgt);
    end
    set_flags(4'b1000);
    drive_branch(2'd1, 32'h300, 0, 0, 4'b0, 1'b0, o);
    checks++;
    if (o.ldn !== 0 || o.fl !== 0 || o.rdy !== 1) begin
      errors++;
      $display("[TB] FAIL jgt_not_taken got loads %0d fl %0d rdy %0d exp 0 0 1", o.ldn, o.fl, o.rdy);
    end
  endtask

  task automatic test_jeq_pend();
    obs_t o;
    drive_branch(2'd3, 32'h400, 2, 3, 4'b0100, 1'b0, o);
    checks++;
    if (o.st0 !== 1 || o.st !== 4) begin
      errors++;
      $display("[TB] FAIL jeq_pend_stall got st0 %0d st %0d exp 1 4", o.st0, o.st);
    end
    checks++;
    if (o.ld !== 4 || o.ld_tgt !== 32'h400 || flags_q !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL jeq_pend_load got cyc %0d tgt %h flags %b exp 4 400 0100", o.ld, o.ld_tgt, flags_q);
    end
    model_flags = 4'b0100;
  endtask

  task automatic test_bypass();
    obs_t o;
    set_flags(4'b0000);
    drive_branch(2'd3, 32'h500, 1, 0, 4'b0100, 1'b0, o);
    checks++;
    if (o.st !== 0 || o.ld !== 1 || flags_q !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL bypass got st %0d ld %0d flags %b exp 0 1 0100", o.st, o.ld, flags_q);
    end
    model_flags = 4'b0100;
  endtask

  task automatic test_timeout();
    obs_t o;
    set_flags(4'b0010);
    drive_branch(2'd2, 32'h600, 2, 0, 4'b0000, 1'b0, o);
    checks++;
    if (o.to !== WAIT_MAX || o.ton !== 1) begin
      errors++;
      $display("[TB] FAIL timeout_pulse got cyc %0d count %0d exp %0d 1", o.to, o.ton, WAIT_MAX);
    end
    checks++;
    if (o.ld !== WAIT_MAX + 1 || o.ld_tgt !== 32'h600 || o.rdy !== WAIT_MAX + 3) begin
      errors++;
      $display("[TB] FAIL timeout_resolve got ld %0d tgt %h rdy %0d exp %0d 600 %0d",
               o.ld, o.ld_tgt, o.rdy, WAIT_MAX + 1, WAIT_MAX + 3);
    end
  endtask

  task automatic test_hold();
    obs_t o;
    set_flags(4'b0000);
    drive_branch(2'd3, 32'h700, 2, 2, 4'b0100, 1'b1, o);
    checks++;
    if (o.ld !== 3 || o.ld_tgt !== 32'h700 || o.end_tgt !== 32'h700) begin
      errors++;
      $display("[TB] FAIL hold_ignored got ld %0d tgt %h end %h exp 3 700 700", o.ld, o.ld_tgt, o.end_tgt);
    end
    model_flags = 4'b0100;
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [1:0] c;
    logic [31:0] tgt;
    logic [3:0] nf;
    int mode, w;
    bit hold;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) set_flags(4'($urandom));
      c = 2'($urandom); tgt = $urandom; nf = 4'($urandom);
      mode = $urandom_range(0, 2);
      w = $urandom_range(0, WAIT_MAX);
      if (c == 2'd0 && mode == 2) w = 0;
      hold = 1'($urandom);
      e = model_branch(c, mode, w, nf, model_flags);
      drive_branch(c, tgt, mode, w, nf, hold, o);
      checks++;
      if (o.ld !== e.ld || o.ldn !== (e.ld > 0 ? 1 : 0)) begin
        errors++;
        $display("[TB] FAIL rnd%0d_load got cyc %0d n %0d exp cyc %0d", i, o.ld, o.ldn, e.ld);
      end
      checks++;
      if (e.ld > 0 && o.ld_tgt !== tgt) begin
        errors++;
        $display("[TB] FAIL rnd%0d_target got %h exp %h", i, o.ld_tgt, tgt);
      end
      checks++;
      if (o.fl !== e.fl || o.rdy !== e.rdy || o.st !== e.st) begin
        errors++;
        $display("[TB] FAIL rnd%0d_timing got fl %0d rdy %0d st %0d exp %0d %0d %0d",
                 i, o.fl, o.rdy, o.st, e.fl, e.rdy, e.st);
      end
      checks++;
      if (o.to !== e.to || o.ton !== (e.to > 0 ? 1 : 0)) begin
        errors++;
        $display("[TB] FAIL rnd%0d_timeout got cyc %0d n %0d exp %0d", i, o.to, o.ton, e.to);
      end
      checks++;
      if (flags_q !== e.flags_after || o.end_tgt !== tgt) begin
        errors++;
        $display("[TB] FAIL rnd%0d_state got flags %b end %h exp %b %h", i, flags_q, o.end_tgt, e.flags_after, tgt);
      end
      model_flags = e.flags_after;
    end
  endtask

  initial begin
    rst = 1'b1; br_valid = 1'b0; br_cond = 2'd0; br_target = '0;
    flag_we = 1'b0; alu_flags = 4'b0; flag_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    $display("[TB] starting");
    test_reset();
    test_jmp();
    test_jgt();
    test_jeq_pend();
    test_bypass();
    test_timeout();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
